decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode pipeline stage for the 16-bit core. It accepts one instruction per cycle through a valid/ready handshake and emits registered control fields: ALU select, write-back, memory, branch and sign-extend. It keeps its own history of the last FWD_DEPTH issued instructions, so no before-command inputs are needed. From that history it generates one-hot operand-forwarding selects and an optional load-use interlock. It sits between instruction fetch and the execute/register-read stage.

## Interface
- FWD_DEPTH, 2: number of history entries checked for forwarding (1..4).
- RA_W, 3: register address width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_instr  in  16  instruction word.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- flush  in  1  discard the output register and the history (taken branch).
- out_ready  in  1  downstream accepts the output.
- out_valid  out  1  output fields are valid.
- s_alu  out  4  ALU select.
- sign_ex  out  1  sign-extend the immediate.
- ar_mux, br_mux  out  1 each  operand source muxes.
- reg_we  out  1  register write-back enable.
- wr_addr  out  RA_W  write-back address.
- mem_we  out  1  store enable.
- pc_load  out  1  branch / conditional branch.
- cond  out  3  branch condition, [10:8].
- fwd_a, fwd_b  out  FWD_DEPTH each  one-hot forward selects; bit k selects the result of the instruction k+1 ahead.

## Operation
- Field decode, with op = [15:14] and f = [7:4]:
  - f applies to op 11 only. s_alu = f, except f=0101 (CMP) → 0001 and f=0110 (MOV) → 1100.
  - op 00/01 (LD/ST) → 0000.
  - [15:11]=10000 (LI) → 1100.
  - [15:11]=10001 (ADDI), 10100 (B) and 10111 (BC) → 0000.
  - Anything else → 1111.
- Writers and destinations:
  - op 11 with f≤1100, f≠0101, f≠0111: destination [10:8].
  - LD (op 00): destination [13:11].
  - LI and ADDI: destination [10:8].
- Source A is [10:8]. It is used by:
  - op 11 with f∈{0000–0110, 1101};
  - ST.
- Source B is [13:11]. It is used by:
  - op 11 with f∈{0000–0101, 1000–1011};
  - LD;
  - ST.
- Other control fields:
  - mem_we = op 01.
  - pc_load = B or BC.
  - sign_ex = op≠11.
  - ar_mux = op 11 and f≤0110.
  - br_mux = !(op 10 and [13]).
- load_en = !out_valid | out_ready. On load_en the output register takes the new instruction, or a bubble (out_valid=0, all enables 0) when none is accepted.
- History: a shift register of {valid, writer, is_ld, dest}. It shifts on every load_en, and bubbles shift in as invalid entries, so entry k is exactly k+1 issue slots ahead.
- fwd_a[k] = 1 when all of these hold:
  - source A is used;
  - entry k is valid and a writer;
  - its dest equals source A;
  - no lower k also matches (nearest wins).
- fwd_b is defined the same way on source B. Register 0 is not special.
- Forward selects are computed against the history before the shift and registered together with the other fields.
- in_ready = load_en & !interlock.
- flush clears out_valid and every history valid bit. flush wins over a simultaneous accept; in_ready is forced 0 in the flush cycle.

## Timing
- Latency 1 cycle; throughput 1 instruction per cycle without hazards.
- Reset values:
  - out_valid=0, all enables=0, s_alu=1111, wr_addr=0, cond=0, fwd_*=0;
  - history invalid;
  - in_ready=1 in the first cycle after reset.
- While out_valid=1 and out_ready=0, every output holds stable and the history holds.
- Reset during a stall or interlock returns the stage to the reset state on the next edge; no instruction is retained.

## Configuration
- DECODE_LOAD_INTERLOCK_EN defined: when entry 0 is a valid LD and the candidate uses a source equal to its dest, interlock=1. in_ready drops for exactly one load_en, one bubble is inserted, and the instruction then issues with fwd_*[1] set.
- Undefined: interlock is tied 0 and no bubble is inserted. fwd_*[0] is still asserted against an LD; software schedules around it.

## Structure
- Package decode_pkg holds:
  - opcode and function constants (LD, ST, LI, ADDI, B, BC, CMP, MOV);
  - ALU select constants IADD=0000, ISUB=0001, IIDT=1100, INON=1111;
  - the history entry struct.
- Sub-module decode_fields: purely combinational single-instruction decoder producing fields, srcA/srcB/used, writer, is_ld and dest. It is instantiated once and its outputs are stored in the history.

## Test plan
- Reset, then issue ADD r1 (f=0000, [10:8]=1, [13:11]=2), out_ready=1 → next cycle out_valid=1, s_alu=0000, reg_we=1, wr_addr=1, fwd_a=fwd_b=0.
- ADD r3 then SUB reading A=r3 back-to-back → fwd_a=01; insert one NOP between them → fwd_a=10 (FWD_DEPTH=2).
- Two writers to r3, then a reader of r3 → fwd_a selects bit 0 only (nearest wins).
- LD r4 then ADD using r4, with macro defined → in_ready=0 for one cycle, one bubble, then ADD issues with fwd_b=10. Without the macro → no bubble, fwd_b=01.
- out_ready=0 for 3 cycles with out_valid=1 → all outputs and in_ready=0 stable; release → resumes with no loss or duplication.
- flush asserted together with in_valid → next cycle out_valid=0, instruction dropped, subsequent reader of prior dest gets fwd=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode/function constants, ALU selects and the decoded-field and
// history-entry types for the decode stage.
package decode_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_IMM = 2'b10,
    OP_ALU = 2'b11
  } op_e;

  localparam logic [4:0] OP5_LI   = 5'b10000;
  localparam logic [4:0] OP5_ADDI = 5'b10001;
  localparam logic [4:0] OP5_B    = 5'b10100;
  localparam logic [4:0] OP5_BC   = 5'b10111;

  localparam logic [3:0] F_CMP = 4'b0101;
  localparam logic [3:0] F_MOV = 4'b0110;

  localparam logic [3:0] IADD = 4'b0000;
  localparam logic [3:0] ISUB = 4'b0001;
  localparam logic [3:0] IIDT = 4'b1100;
  localparam logic [3:0] INON = 4'b1111;

  localparam int unsigned REG_AW = 3;

  typedef struct packed {
    logic              valid;
    logic              writer;
    logic              is_ld;
    logic [REG_AW-1:0] dest;
  } hist_t;

  typedef struct packed {
    logic [3:0]        s_alu;
    logic              sign_ex;
    logic              ar_mux;
    logic              br_mux;
    logic              mem_we;
    logic              pc_load;
    logic [2:0]        cond;
    logic              writer;
    logic              is_ld;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              use_a;
    logic              use_b;
  } dec_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        s_alu;
    logic              sign_ex;
    logic              ar_mux;
    logic              br_mux;
    logic              reg_we;
    logic              mem_we;
    logic              pc_load;
    logic [2:0]        cond;
    logic [REG_AW-1:0] wr_addr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, s_alu: INON, default: '0};

endpackage

// File: rtl/decode_fields.sv
// Purely combinational single-instruction decoder: control fields, register
// sources and their use flags, and write-back destination.
module decode_fields
  import decode_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_t        dec_o
);

  op_e        op;
  logic [3:0] f;
  logic [4:0] op5;
  logic       is_alu;
  logic       alu_wr;

  always_comb begin
    op     = op_e'(instr_i[15:14]);
    f      = instr_i[7:4];
    op5    = instr_i[15:11];
    is_alu = (op == OP_ALU);
    alu_wr = is_alu && (f <= 4'b1100) && (f != F_CMP) && (f != 4'b0111);

    dec_o = '0;
    if (is_alu) begin
      dec_o.s_alu = (f == F_CMP) ? ISUB : (f == F_MOV) ? IIDT : f;
    end else if (op == OP_LD || op == OP_ST) begin
      dec_o.s_alu = IADD;
    end else if (op5 == OP5_LI) begin
      dec_o.s_alu = IIDT;
    end else if (op5 == OP5_ADDI || op5 == OP5_B || op5 == OP5_BC) begin
      dec_o.s_alu = IADD;
    end else begin
      dec_o.s_alu = INON;
    end

    dec_o.sign_ex = !is_alu;
    dec_o.ar_mux  = is_alu && (f <= 4'b0110);
    dec_o.br_mux  = !(op == OP_IMM && instr_i[13]);
    dec_o.mem_we  = (op == OP_ST);
    dec_o.pc_load = (op5 == OP5_B) || (op5 == OP5_BC);
    dec_o.cond    = instr_i[10:8];
    dec_o.is_ld   = (op == OP_LD);
    dec_o.writer  = alu_wr || (op == OP_LD) || (op5 == OP5_LI) || (op5 == OP5_ADDI);
    dec_o.dest    = (op == OP_LD) ? instr_i[13:11] : instr_i[10:8];
    dec_o.src_a   = instr_i[10:8];
    dec_o.src_b   = instr_i[13:11];
    dec_o.use_a   = (is_alu && (f <= 4'b0110 || f == 4'b1101)) || (op == OP_ST);
    dec_o.use_b   = (is_alu && (f <= 4'b0101 || (f >= 4'b1000 && f <= 4'b1011)))
                    || (op == OP_LD) || (op == OP_ST);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with issue history, one-hot operand forwarding and
// an optional load-use interlock enabled by DECODE_LOAD_INTERLOCK_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned RA_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          in_instr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [3:0]           s_alu,
  output logic                 sign_ex,
  output logic                 ar_mux,
  output logic                 br_mux,
  output logic                 reg_we,
  output logic [RA_W-1:0]      wr_addr,
  output logic                 mem_we,
  output logic                 pc_load,
  output logic [2:0]           cond,
  output logic [FWD_DEPTH-1:0] fwd_a,
  output logic [FWD_DEPTH-1:0] fwd_b
);

  dec_t                 dec;
  hist_t                hist_q [0:FWD_DEPTH-1];
  ctrl_t                out_d, out_q;
  logic [FWD_DEPTH-1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic                 load_en, interlock, accept;
  logic                 found_a, found_b, unused_is_ld;

  decode_fields u_fields (
    .instr_i (in_instr),
    .dec_o   (dec)
  );

`ifdef DECODE_LOAD_INTERLOCK_EN
  assign interlock = hist_q[0].valid && hist_q[0].is_ld &&
                     ((dec.use_a && hist_q[0].dest == dec.src_a) ||
                      (dec.use_b && hist_q[0].dest == dec.src_b));
`else
  assign interlock = 1'b0;
`endif

  assign load_en  = !out_q.valid || out_ready;
  assign in_ready = load_en && !interlock && !flush;
  assign accept   = in_valid && in_ready;

  // Nearest matching history entry wins; selects use the pre-shift history.
  always_comb begin
    fwd_a_d = '0;
    fwd_b_d = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    unused_is_ld = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      unused_is_ld ^= hist_q[k].is_ld;
      if (hist_q[k].valid && hist_q[k].writer) begin
        if (!found_a && dec.use_a && hist_q[k].dest == dec.src_a) begin
          fwd_a_d[k] = 1'b1;
          found_a    = 1'b1;
        end
        if (!found_b && dec.use_b && hist_q[k].dest == dec.src_b) begin
          fwd_b_d[k] = 1'b1;
          found_b    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_d = CTRL_BUBBLE;
    if (accept) begin
      out_d.valid   = 1'b1;
      out_d.s_alu   = dec.s_alu;
      out_d.sign_ex = dec.sign_ex;
      out_d.ar_mux  = dec.ar_mux;
      out_d.br_mux  = dec.br_mux;
      out_d.reg_we  = dec.writer;
      out_d.mem_we  = dec.mem_we;
      out_d.pc_load = dec.pc_load;
      out_d.cond    = dec.cond;
      out_d.wr_addr = dec.dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_q   <= CTRL_BUBBLE;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) hist_q[k] <= '0;
    end else if (load_en) begin
      out_q   <= out_d;
      fwd_a_q <= accept ? fwd_a_d : '0;
      fwd_b_q <= accept ? fwd_b_d : '0;
      hist_q[0] <= accept ? hist_t'{1'b1, dec.writer, dec.is_ld, dec.dest} : hist_t'('0);
      for (int unsigned k = 1; k < FWD_DEPTH; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  assign out_valid = out_q.valid;
  assign s_alu     = out_q.s_alu;
  assign sign_ex   = out_q.sign_ex;
  assign ar_mux    = out_q.ar_mux;
  assign br_mux    = out_q.br_mux;
  assign reg_we    = out_q.reg_we;
  assign wr_addr   = RA_W'(out_q.wr_addr);
  assign mem_we    = out_q.mem_we;
  assign pc_load   = out_q.pc_load;
  assign cond      = out_q.cond;
  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions with hand-computed
// expected fields; honours DECODE_LOAD_INTERLOCK_EN for the load-use case.
module tb_decode_stage;

  typedef struct packed {
    logic [3:0] s_alu;
    logic       sign_ex;
    logic       ar_mux;
    logic       br_mux;
    logic       reg_we;
    logic [2:0] wr_addr;
    logic       mem_we;
    logic       pc_load;
    logic [2:0] cond;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } exp_t;

`ifdef DECODE_LOAD_INTERLOCK_EN
  localparam logic [1:0] LU_FWD_B = 2'b10;
  localparam int         LU_STALL = 1;
`else
  localparam logic [1:0] LU_FWD_B = 2'b01;
  localparam int         LU_STALL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_ready, out_valid;
  logic [15:0] in_instr;
  logic [3:0]  s_alu;
  logic        sign_ex, ar_mux, br_mux, reg_we, mem_we, pc_load;
  logic [2:0]  wr_addr, cond;
  logic [1:0]  fwd_a, fwd_b;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  decode_stage #(.FWD_DEPTH(2), .RA_W(3)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .s_alu(s_alu), .sign_ex(sign_ex),
    .ar_mux(ar_mux), .br_mux(br_mux), .reg_we(reg_we), .wr_addr(wr_addr),
    .mem_we(mem_we), .pc_load(pc_load), .cond(cond),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t E(input logic [3:0] s, input logic sx, ar, br, we,
                             input logic [2:0] wr, input logic mem, pc,
                             input logic [2:0] cnd, input logic [1:0] fa, fb);
    E = '{s, sx, ar, br, we, wr, mem, pc, cnd, fa, fb};
  endfunction

  // Monitor: one pop per output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(s_alu), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_fields", 32'(exp_t'{s_alu, sign_ex, ar_mux, br_mux, reg_we, wr_addr,
                                    mem_we, pc_load, cond, fwd_a, fwd_b}), 32'(e));
      end
    end
  end

  // Entered and left at posedge+#1.
  task automatic send(input logic [15:0] ins, input exp_t e, input int exp_stall);
    int stalls = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    exp_q.push_back(e);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_s_alu", 32'(s_alu), 32'hF);
    chk("rst_enables", 32'({reg_we, mem_we, pc_load}), 0);
    chk("rst_wr_cond", 32'({wr_addr, cond}), 0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Basic ADD r1 and field decode of ST / BC / CMP
    send(16'hD100, E(4'b0000, 0, 1, 1, 1, 3'd1, 0, 0, 3'd1, 2'b00, 2'b00), 0);
    idle(3);
    send(16'h5308, E(4'b0000, 1, 0, 1, 0, 3'd3, 1, 0, 3'd3, 2'b00, 2'b00), 0);
    send(16'hBA10, E(4'b0000, 1, 0, 0, 0, 3'd2, 0, 1, 3'd2, 2'b00, 2'b00), 0);
    send(16'hDA50, E(4'b0001, 0, 1, 1, 0, 3'd2, 0, 0, 3'd2, 2'b00, 2'b00), 0);

    // ADD r3 -> SUB reading r3 back-to-back
    idle(3);
    send(16'hC300, E(4'b0000, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);
    send(16'hEB10, E(4'b0001, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b01, 2'b00), 0);

    // ADD r3, NOP, SUB reading r3
    idle(3);
    send(16'hC300, E(4'b0000, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);
    send(16'hC0F0, E(4'b1111, 0, 0, 1, 0, 3'd0, 0, 0, 3'd0, 2'b00, 2'b00), 0);
    send(16'hEB10, E(4'b0001, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b10, 2'b00), 0);

    // Two writers of r3, nearest wins
    idle(3);
    send(16'hC300, E(4'b0000, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);
    send(16'h8305, E(4'b1100, 1, 0, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);
    send(16'hEB10, E(4'b0001, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b01, 2'b00), 0);

    // Load-use: LD r4 then ADD reading r4 on source B
    idle(3);
    send(16'h2100, E(4'b0000, 1, 0, 1, 1, 3'd4, 0, 0, 3'd1, 2'b00, 2'b00), 0);
    send(16'hE600, E(4'b0000, 0, 1, 1, 1, 3'd6, 0, 0, 3'd6, 2'b00, LU_FWD_B), LU_STALL);

    // Downstream stall for 3 cycles with a MOV waiting
    idle(3);
    send(16'hD100, E(4'b0000, 0, 1, 1, 1, 3'd1, 0, 0, 3'd1, 2'b00, 2'b00), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'hC960;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_fields", 32'({s_alu, reg_we, wr_addr, cond}), 32'({4'b0000, 1'b1, 3'd1, 3'd1}));
      chk("stall_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'hC960, E(4'b1100, 0, 1, 1, 1, 3'd1, 0, 0, 3'd1, 2'b01, 2'b00), 0);

    // Flush together with in_valid
    idle(3);
    send(16'hC300, E(4'b0000, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h8505;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    send(16'hEB10, E(4'b0001, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);

    // Reset while stalled
    idle(3);
    send(16'hD100, E(4'b0000, 0, 1, 1, 1, 3'd1, 0, 0, 3'd1, 2'b00, 2'b00), 0);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_stall_out_valid", 32'(out_valid), 0);
    chk("rst_stall_s_alu", 32'(s_alu), 32'hF);
    chk("rst_stall_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'hEB10, E(4'b0001, 0, 1, 1, 1, 3'd3, 0, 0, 3'd3, 2'b00, 2'b00), 0);

    idle(4);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
